mux_sel_arbiter: RTL

- Round-robin arbiter for two requesters sharing one 2:1 mux.
- Sits directly upstream of the 2:1 mux. sel_out drives the mux select input: 0 selects input A, 1 selects input B.
- Grants are held while the requester keeps requesting, with a bounded hold time so neither source starves.
- All outputs are registered, so the mux select is glitch-free.

---
 rtl/mux_sel_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter for two requesters that share one 2:1 mux.
// sel_out drives the mux select (0 = A, 1 = B). A grant is held while its owner
// keeps requesting, but never for more than HOLD_MAX cycles while the other side
// is also waiting. Every output comes straight from a flop, so the select is
// glitch-free and no input reaches an output combinationally.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_a_in,
  input  logic             req_b_in,
  output logic             grant_a_out,
  output logic             grant_b_out,
  output logic             sel_out,
  output logic             busy_out,
  output logic             switch_out,
  output logic [CNT_W-1:0] hold_cnt_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // Last hold count value before the grant is forced over to a waiting requester.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_b;
  logic             last_b_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             sel_nxt;
  logic             switch_nxt;

  // Next-state, hold counter, select and switch-pulse decisions.
  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    hold_nxt   = '0;
    sel_nxt    = sel_out;
    switch_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req_a_in && (!req_b_in || last_b)) begin
          state_nxt  = OWN_A;
          sel_nxt    = 1'b0;
          last_b_nxt = 1'b0;
        end else if (req_b_in) begin
          state_nxt  = OWN_B;
          sel_nxt    = 1'b1;
          last_b_nxt = 1'b1;
        end
      end
      OWN_A: begin
        if (req_b_in && (!req_a_in || hold_cnt == HOLD_LAST)) begin
          state_nxt  = OWN_B;
          sel_nxt    = 1'b1;
          last_b_nxt = 1'b1;
          switch_nxt = 1'b1;
        end else if (!req_a_in) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      OWN_B: begin
        if (req_a_in && (!req_b_in || hold_cnt == HOLD_LAST)) begin
          state_nxt  = OWN_A;
          sel_nxt    = 1'b0;
          last_b_nxt = 1'b0;
          switch_nxt = 1'b1;
        end else if (!req_b_in) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; after reset B counts as last owner so A wins the first tie.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_b   <= last_b_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Registered outputs, loaded from the same decisions as the state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_a_out  <= 1'b0;
      grant_b_out  <= 1'b0;
      busy_out     <= 1'b0;
      sel_out      <= 1'b0;
      switch_out   <= 1'b0;
      hold_cnt_out <= '0;
    end else begin
      grant_a_out  <= (state_nxt == OWN_A);
      grant_b_out  <= (state_nxt == OWN_B);
      busy_out     <= (state_nxt != IDLE);
      sel_out      <= sel_nxt;
      switch_out   <= switch_nxt;
      hold_cnt_out <= hold_nxt;
    end
  end

endmodule
